// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding and width helpers.
package mult_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

  // Number of RUN cycles per operation; bits_per_cycle must divide width exactly.
  function automatic int mul_cycles(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: acc plus mcand shifted by offset+i for every set bit i of the slice.
// Purely combinational; no state, no backpressure.
module mult_step
  import mult_pkg::*;
#(
  parameter  int WIDTH          = 16,
  parameter  int BITS_PER_CYCLE = 1,
  localparam int PROD_W         = prod_width(WIDTH),
  localparam int OFF_W          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [PROD_W-1:0]         acc,
  input  logic [WIDTH-1:0]          mcand,
  input  logic [BITS_PER_CYCLE-1:0] slice,
  input  logic [OFF_W-1:0]          offset,
  output logic [PROD_W-1:0]         sum
);

  logic [PROD_W-1:0] ext;

  always_comb begin
    ext = PROD_W'(mcand);
    sum = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (slice[i]) begin
        sum = sum + (ext << (int'(offset) + i));
      end
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential MULT/MULTU unit: magnitudes are multiplied unsigned, the sign is applied at completion.
// Accept to done = WIDTH/BITS_PER_CYCLE cycles; start_ready only in IDLE, flush aborts without touching hi/lo.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PROD_W = prod_width(WIDTH);
  localparam int NCYC   = mul_cycles(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W  = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int OFF_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e                    state_q, state_d;
  logic [PROD_W-1:0]         acc_q, acc_next, prod_final;
  logic [CNT_W-1:0]          cnt_q;
  logic [WIDTH-1:0]          mcand_q, mplier_q;
  logic                      neg_q;
  logic                      done_q;
  logic [WIDTH-1:0]          hi_q, lo_q;
  logic [WIDTH-1:0]          a_mag, b_mag;
  logic [BITS_PER_CYCLE-1:0] slice;
  logic [OFF_W-1:0]          offset;
  logic                      accept, last, fire;

  // Magnitudes stay WIDTH-bit unsigned so the most negative value maps to 2^(WIDTH-1) intact.
  assign a_mag  = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_mag  = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  assign slice  = mplier_q[cnt_q*BITS_PER_CYCLE +: BITS_PER_CYCLE];
  assign offset = OFF_W'(int'(cnt_q) * BITS_PER_CYCLE);

  mult_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc    (acc_q),
    .mcand  (mcand_q),
    .slice  (slice),
    .offset (offset),
    .sum    (acc_next)
  );

  assign prod_final = neg_q ? -acc_next : acc_next;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = (cnt_q == CNT_W'(NCYC - 1));
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_valid && !flush) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (last) begin
          fire    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= fire;
      if (accept) begin
        mcand_q  <= a_mag;
        mplier_q <= b_mag;
        neg_q    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == ST_RUN) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + 1'b1;
      end
      if (fire) begin
        {hi_q, lo_q} <= prod_final;
      end
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_RUN);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with hand-computed products and cycle counts.
module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic        is_signed;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [15:0] hi;
  logic [15:0] lo;

  int   errors;
  int   checks;
  int   n;
  logic seen;

  mult_seq_ctrl #(
    .WIDTH          (16),
    .BITS_PER_CYCLE (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .is_signed   (is_signed),
    .op_a        (op_a),
    .op_b        (op_b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one op from IDLE and waits (bounded) for done; checks latency and product.
  task automatic run_op(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                        input string tag, input logic [31:0] exp);
    int k;
    start_valid = 1'b1;
    is_signed   = sgn;
    op_a        = a;
    op_b        = b;
    tick();
    start_valid = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'd16);
    chk(tag, {hi, lo}, exp);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    is_signed   = 1'b0;
    op_a        = '0;
    op_b        = '0;
    flush       = 1'b0;
    #3;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset start_ready", {31'd0, start_ready}, 32'd1);
    chk("reset hilo", {hi, lo}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: MULTU 0x00FF * 0x0101 with explicit cycle tracking
    start_valid = 1'b1;
    is_signed   = 1'b0;
    op_a        = 16'h00FF;
    op_b        = 16'h0101;
    tick();
    start_valid = 1'b0;
    chk("t1 start_ready low", {31'd0, start_ready}, 32'd0);
    chk("t1 busy high", {31'd0, busy}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen = seen | done;
    end
    chk("t1 no early done", {31'd0, seen}, 32'd0);
    chk("t1 hilo held in run", {hi, lo}, 32'h0);
    tick();
    chk("t1 done at 16", {31'd0, done}, 32'd1);
    chk("t1 product", {hi, lo}, 32'h0000_FFFF);
    tick();
    chk("t1 done single", {31'd0, done}, 32'd0);
    chk("t1 busy low after", {31'd0, busy}, 32'd0);
    chk("t1 start_ready after", {31'd0, start_ready}, 32'd1);

    // 2: sign handling
    run_op(1'b1, 16'hFFFF, 16'h0002, "t2 mult -1*2", 32'hFFFF_FFFE);
    run_op(1'b0, 16'hFFFF, 16'h0002, "t2 multu ffff*2", 32'h0001_FFFE);
    // 3: most negative operand and other corners
    run_op(1'b1, 16'h8000, 16'h8000, "t3 mult min*min", 32'h4000_0000);
    run_op(1'b1, 16'h8000, 16'h0001, "t3 mult min*1", 32'hFFFF_8000);
    run_op(1'b1, 16'h0000, 16'hFFFF, "t3 mult 0*-1", 32'h0000_0000);
    run_op(1'b1, 16'hFFFD, 16'hFFFB, "t3 mult -3*-5", 32'h0000_000F);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, "t3 multu max*max", 32'hFFFE_0001);

    // 4: second start held through RUN is taken in the done cycle
    start_valid = 1'b1;
    is_signed   = 1'b0;
    op_a        = 16'h0002;
    op_b        = 16'h0003;
    tick();
    is_signed = 1'b1;
    op_a      = 16'h0007;
    op_b      = 16'hFFFE;
    chk("t4 held start not ready", {31'd0, start_ready}, 32'd0);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("t4 first latency", 32'(n), 32'd16);
    chk("t4 first product", {hi, lo}, 32'h0000_0006);
    chk("t4 ready in done cycle", {31'd0, start_ready}, 32'd1);
    tick();
    start_valid = 1'b0;
    n = 1;
    chk("t4 second accepted", {31'd0, busy}, 32'd1);
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("t4 done to done", 32'(n), 32'd17);
    chk("t4 second product", {hi, lo}, 32'hFFFF_FFF2);

    // 5: flush behaviour against a known prior result
    run_op(1'b0, 16'h1234, 16'h5678, "t5 prior", 32'h0626_0060);
    start_valid = 1'b1;
    is_signed   = 1'b0;
    op_a        = 16'hFFFF;
    op_b        = 16'hFFFF;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5 idle after flush", {31'd0, busy}, 32'd0);
    chk("t5 ready after flush", {31'd0, start_ready}, 32'd1);
    chk("t5 no done on flush", {31'd0, done}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | done;
    end
    chk("t5 no done later", {31'd0, seen}, 32'd0);
    chk("t5 hilo kept", {hi, lo}, 32'h0626_0060);
    start_valid = 1'b1;
    flush       = 1'b1;
    tick();
    start_valid = 1'b0;
    flush       = 1'b0;
    chk("t5 idle flush blocks start", {31'd0, busy}, 32'd0);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5 last-cycle flush no done", {31'd0, done}, 32'd0);
    chk("t5 last-cycle flush hilo", {hi, lo}, 32'h0626_0060);
    chk("t5 last-cycle flush idle", {31'd0, start_ready}, 32'd1);

    // 6: asynchronous reset mid-RUN
    start_valid = 1'b1;
    is_signed   = 1'b1;
    op_a        = 16'h0100;
    op_b        = 16'h0100;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 async busy", {31'd0, busy}, 32'd0);
    chk("t6 async done", {31'd0, done}, 32'd0);
    chk("t6 async hilo", {hi, lo}, 32'h0);
    chk("t6 async ready", {31'd0, start_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | done;
    end
    chk("t6 no done after reset", {31'd0, seen}, 32'd0);
    run_op(1'b0, 16'h0003, 16'h0005, "t6 fresh 3*5", 32'h0000_000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
